// File: rtl/sha_pkg.sv
// Shared SHA-256 definitions: block/word geometry, padder state encoding and the
// initial-hash and round-constant tables consumed by the compression main loop.
package sha_pkg;
  localparam int SHA_BLOCK_W     = 512;
  localparam int SHA_WORD_W      = 32;
  localparam int SHA_LEN_FIELD_W = 64;
  localparam int SHA_BLOCK_WORDS = SHA_BLOCK_W / SHA_WORD_W;

  typedef logic [SHA_WORD_W-1:0]      sha_word_t;
  typedef logic [SHA_BLOCK_W-1:0]     sha_block_t;
  typedef logic [SHA_LEN_FIELD_W-1:0] sha_len_t;

  typedef enum logic [1:0] {S_FILL, S_PAD, S_EMIT} pad_state_t;

  localparam sha_word_t SHA_MARKER_WORD = 32'h8000_0000;

  localparam sha_word_t SHA_H0 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam sha_word_t SHA_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
endpackage

// File: rtl/sha_msg_padder_if.sv
// Message-word input stream and padded-block output stream of the SHA-256 padder.
interface sha_msg_padder_if import sha_pkg::*; ();
  sha_word_t  in_word;
  logic [2:0] in_bytes;
  logic       in_last;
  logic       in_valid;
  logic       in_ready;
  sha_block_t blk_data;
  logic       blk_last;
  logic       blk_valid;
  logic       blk_ready;

  modport master (
    output in_word, in_bytes, in_last, in_valid, blk_ready,
    input  in_ready, blk_data, blk_last, blk_valid
  );

  modport slave (
    input  in_word, in_bytes, in_last, in_valid, blk_ready,
    output in_ready, blk_data, blk_last, blk_valid
  );
endinterface

// File: rtl/sha_word_mask.sv
// Trims the final message word to its valid bytes and drops the 0x80 marker right
// after them; flags the marker as still pending when the word was completely full.
module sha_word_mask import sha_pkg::*; (
  input  sha_word_t  word,
  input  logic [2:0] bytes,
  input  logic       last,
  output sha_word_t  masked,
  output logic [2:0] count,
  output logic       pending
);
  always_comb begin
    count   = (!last || bytes > 3'd4) ? 3'd4 : bytes;
    pending = last && (count == 3'd4);
    masked  = '0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < count)
        masked[31-8*i -: 8] = word[31-8*i -: 8];
      else if (3'(i) == count)
        masked[31-8*i -: 8] = 8'h80;
    end
  end
endmodule

// File: rtl/sha_msg_padder.sv
// Streaming SHA-256 message padder: packs message words into a 16-word buffer and
// emits padded 512-bit blocks, spilling into an extra block when the length won't fit.
module sha_msg_padder import sha_pkg::*; #(
  parameter int LEN_W = 64
) (
  input logic             clk,
  input logic             rst,
  sha_msg_padder_if.slave bus
);
  pad_state_t       state, state_next;
  sha_word_t        buffer [SHA_BLOCK_WORDS];
  logic [3:0]       idx;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] len_add;
  sha_len_t         len64;
  logic             blk_last_q, need_extra, extra80, pending;
  logic             fits;
  sha_word_t        masked;
  logic [2:0]       count;
  logic             mask_pending;

  sha_word_mask u_mask (
    .word    (bus.in_word),
    .bytes   (bus.in_bytes),
    .last    (bus.in_last),
    .masked  (masked),
    .count   (count),
    .pending (mask_pending)
  );

  always_comb begin
    len64            = '0;
    len64[LEN_W-1:0] = len;
    len_add          = bus.in_last ? (LEN_W'(count) << 3) : LEN_W'(32);
    fits             = ({1'b0, idx} + {4'd0, pending}) <= 5'd13;
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_FILL;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FILL: if (bus.in_valid) begin
        if (bus.in_last)        state_next = S_PAD;
        else if (idx == 4'd15)  state_next = S_EMIT;
      end
      S_PAD:  state_next = S_EMIT;
      S_EMIT: if (bus.blk_ready && !need_extra) state_next = S_FILL;
      default: state_next = S_FILL;
    endcase
  end

  always_comb begin
    bus.in_ready  = rst && (state == S_FILL);
    bus.blk_valid = rst && (state == S_EMIT);
    bus.blk_last  = blk_last_q;
    bus.blk_data  = '0;
    for (int i = 0; i < SHA_BLOCK_WORDS; i++)
      bus.blk_data[SHA_BLOCK_W-1-SHA_WORD_W*i -: SHA_WORD_W] = buffer[i];
  end

  // Buffer words past idx are rewritten in S_PAD so the marker/length land correctly
  // whether or not a spill block follows.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx        <= '0;
      len        <= '0;
      blk_last_q <= 1'b0;
      need_extra <= 1'b0;
      extra80    <= 1'b0;
      pending    <= 1'b0;
      for (int i = 0; i < SHA_BLOCK_WORDS; i++) buffer[i] <= '0;
    end else begin
      case (state)
        S_FILL: if (bus.in_valid) begin
          buffer[idx] <= masked;
          len         <= len + len_add;
          pending     <= mask_pending;
          if (!bus.in_last) begin
            if (idx == 4'd15) begin
              blk_last_q <= 1'b0;
              idx        <= '0;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        S_PAD: begin
          for (int i = 0; i < SHA_BLOCK_WORDS; i++) begin
            if (5'(i) > {1'b0, idx})
              buffer[i] <= (pending && 5'(i) == {1'b0, idx} + 5'd1) ? SHA_MARKER_WORD : '0;
          end
          if (fits) begin
            buffer[14] <= len64[63:32];
            buffer[15] <= len64[31:0];
            blk_last_q <= 1'b1;
          end else begin
            need_extra <= 1'b1;
            extra80    <= pending && (idx == 4'd15);
            blk_last_q <= 1'b0;
          end
        end
        S_EMIT: if (bus.blk_ready) begin
          if (need_extra) begin
            buffer[0] <= extra80 ? SHA_MARKER_WORD : '0;
            for (int i = 1; i < 14; i++) buffer[i] <= '0;
            buffer[14] <= len64[63:32];
            buffer[15] <= len64[31:0];
            blk_last_q <= 1'b1;
            need_extra <= 1'b0;
            extra80    <= 1'b0;
          end else begin
            if (blk_last_q) begin
              len <= '0;
              idx <= '0;
            end
            blk_last_q <= 1'b0;
            for (int i = 0; i < SHA_BLOCK_WORDS; i++) buffer[i] <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sha_msg_padder.sv
// Self-checking bench for sha_msg_padder: directed SHA padding cases, backpressure and
// reset, plus random messages compared against a byte-level padding reference model.
module tb_sha_msg_padder;
  import sha_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  sha_block_t exp_q[$];
  sha_block_t last_blk;
  logic [7:0] msg_buf[$];

  sha_msg_padder_if bus ();

  sha_msg_padder #(.LEN_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference: textbook SHA-256 padding on a byte array, then cut into 64-byte blocks.
  task automatic buildExpected(input logic [7:0] msg[$]);
    logic [7:0]  p[$];
    logic [63:0] bitlen;
    sha_block_t  blk;
    p      = msg;
    bitlen = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bitlen[8*i +: 8]);
    exp_q.delete();
    for (int b = 0; b < p.size() / 64; b++) begin
      blk = '0;
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*b+j];
      exp_q.push_back(blk);
    end
  endtask

  task automatic makeMsg(input int n);
    msg_buf.delete();
    for (int i = 0; i < n; i++) msg_buf.push_back(8'($urandom));
  endtask

  task automatic applyStimulus(input logic [7:0] msg[$], input bit empty_tail, input string name);
    sha_word_t  wq[$];
    logic [2:0] bq[$];
    logic       lq[$];
    sha_word_t  w;
    int n     = msg.size();
    int nfull = n / 4;
    int rem   = n % 4;
    int wi    = 0;
    int bi    = 0;
    int cyc   = 0;
    bit took  = 1'b0;
    buildExpected(msg);
    for (int i = 0; i < nfull; i++) begin
      w = {msg[4*i], msg[4*i+1], msg[4*i+2], msg[4*i+3]};
      wq.push_back(w);
      bq.push_back(3'($urandom_range(0, 7)));
      lq.push_back(1'b0);
    end
    if (rem != 0) begin
      w = $urandom;
      for (int j = 0; j < rem; j++) w[31-8*j -: 8] = msg[4*nfull+j];
      wq.push_back(w);
      bq.push_back(3'(rem));
      lq.push_back(1'b1);
    end else if (n == 0 || empty_tail) begin
      wq.push_back($urandom);
      bq.push_back(3'd0);
      lq.push_back(1'b1);
    end else begin
      bq[nfull-1] = 3'($urandom_range(4, 7));
      lq[nfull-1] = 1'b1;
    end
    while ((wi < wq.size() || bi < exp_q.size()) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (took) begin
        bus.in_valid = 1'b0;
        wi++;
        took = 1'b0;
      end
      if (!bus.in_valid && wi < wq.size() && $urandom_range(0, 3) != 0) begin
        bus.in_word  = wq[wi];
        bus.in_bytes = bq[wi];
        bus.in_last  = lq[wi];
        bus.in_valid = 1'b1;
      end
      bus.blk_ready = ($urandom_range(0, 2) != 0);
      #1;
      took = bus.in_valid && bus.in_ready;
      if (bus.blk_valid && bus.blk_ready) begin
        if (bi < exp_q.size()) begin
          checkOutput({name, "_data"}, bus.blk_data, exp_q[bi]);
          checkOutput({name, "_last"}, 512'(bus.blk_last), 512'(bi == exp_q.size() - 1));
        end else begin
          checkOutput({name, "_block_count"}, 512'(bi + 1), 512'(exp_q.size()));
        end
        last_blk = bus.blk_data;
        bi++;
      end
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.blk_ready = 1'b0;
    #1;
    checkOutput({name, "_in_time"}, 512'(cyc < 2000), 512'(1));
    checkOutput({name, "_idle_ready"}, 512'(bus.in_ready), 512'(1));
  endtask

  task automatic sendWord(input sha_word_t w, input logic [2:0] b, input logic l);
    int waited = 0;
    @(negedge clk);
    bus.in_word  = w;
    bus.in_bytes = b;
    bus.in_last  = l;
    bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    checkOutput("send_accept", 512'(bus.in_ready), 512'(1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    sha_word_t  words [16];
    sha_block_t sent;

    bus.in_word   = '0;
    bus.in_bytes  = '0;
    bus.in_last   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.blk_ready = 1'b0;

    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 512'(bus.in_ready), 512'(0));
    checkOutput("rst_blk_valid", 512'(bus.blk_valid), 512'(0));
    checkOutput("rst_blk_last", 512'(bus.blk_last), 512'(0));
    checkOutput("rst_blk_data", bus.blk_data, 512'(0));
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("post_rst_in_ready", 512'(bus.in_ready), 512'(1));

    msg_buf = '{8'h61, 8'h62, 8'h63};
    applyStimulus(msg_buf, 1'b0, "abc");
    checkOutput("abc_const", last_blk, {32'h61626380, 448'd0, 32'h00000018});

    msg_buf.delete();
    applyStimulus(msg_buf, 1'b0, "empty");
    checkOutput("empty_const", last_blk, {32'h80000000, 480'd0});

    makeMsg(55); applyStimulus(msg_buf, 1'b0, "len55");
    makeMsg(56); applyStimulus(msg_buf, 1'b0, "len56");
    makeMsg(64); applyStimulus(msg_buf, 1'b0, "len64");
    makeMsg(64); applyStimulus(msg_buf, 1'b1, "len64_tail");
    makeMsg(59); applyStimulus(msg_buf, 1'b0, "len59");
    makeMsg(63); applyStimulus(msg_buf, 1'b0, "len63");
    makeMsg(8);  applyStimulus(msg_buf, 1'b1, "len8_tail");

    // Full block held under backpressure, then reset while it is still being offered.
    for (int i = 0; i < 16; i++) begin
      words[i] = $urandom;
      sendWord(words[i], 3'($urandom_range(0, 7)), 1'b0);
    end
    sent = '0;
    for (int i = 0; i < 16; i++) sent[511-32*i -: 32] = words[i];
    @(negedge clk);
    #1;
    checkOutput("bp_valid", 512'(bus.blk_valid), 512'(1));
    checkOutput("bp_last", 512'(bus.blk_last), 512'(0));
    checkOutput("bp_data", bus.blk_data, sent);
    repeat (10) begin
      @(negedge clk);
      #1;
      checkOutput("bp_hold", bus.blk_data, sent);
      checkOutput("bp_in_ready", 512'(bus.in_ready), 512'(0));
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_emit_valid", 512'(bus.blk_valid), 512'(0));
    checkOutput("rst_emit_data", bus.blk_data, 512'(0));
    @(negedge clk);
    rst = 1'b1;
    msg_buf = '{8'h61, 8'h62, 8'h63};
    applyStimulus(msg_buf, 1'b0, "abc_after_rst");
    checkOutput("abc_after_rst_const", last_blk, {32'h61626380, 448'd0, 32'h00000018});

    for (int k = 0; k < 24; k++) begin
      makeMsg($urandom_range(0, 150));
      applyStimulus(msg_buf, 1'($urandom_range(0, 1)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
